// File: rtl/mult_split_seq_pkg.sv
// Shared types and elaboration-time helpers for the split sequential multiplier.
package mult_split_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Partial-product index: 0=LL, 1=LH, 2=HL, 3=HH
    typedef logic [1:0] step_t;

    // Half width of a W-bit operand.
    function automatic int half_w(input int w);
        return w / 2;
    endfunction

    // Width of the signed (H+1)x(H+1) partial product.
    function automatic int pp_w(input int h);
        return 2 * h + 2;
    endfunction

    // Mask that keeps bits [h-1:trunc] of a low half and clears the rest.
    // Bit h (the zero sign bit of the low half) is cleared as well, which is
    // harmless because it is always zero.
    function automatic logic [63:0] trunc_mask(input int h, input int trunc);
        logic [63:0] keep_h;
        logic [63:0] drop_t;
        keep_h = (64'd1 << h) - 64'd1;
        drop_t = (64'd1 << trunc) - 64'd1;
        return keep_h & ~drop_t;
    endfunction

endpackage

// File: rtl/mult_split_seq_pp_unit.sv
// Combinational (H+1)x(H+1) signed multiplier; the one shared partial-product
// engine. Kept as its own module so approximate cells can be dropped in.
module mult_pp_unit #(
    parameter int H = 8
) (
    input  logic signed [H:0]     i_a,
    input  logic signed [H:0]     i_b,
    output logic signed [2*H+1:0] o_z
);

    // Operands are sign-extended to the result width before multiplying.
    always_comb begin
        o_z = i_a * i_b;
    end

endmodule

// File: rtl/mult_split_seq.sv
// Iterative signed WxW multiplier: four half-width partial products through
// one shared multiplier, accumulated over four cycles, with valid/ready on
// both sides and an optional truncated low x low product.
module mult_split_seq
    import mult_split_pkg::*;
#(
    parameter int W     = 16,
    parameter int TRUNC = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [W-1:0]     i_a,
    input  logic [W-1:0]     i_b,
    input  logic             i_approx,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [2*W-1:0]   o_z,
    output logic             o_busy
);

    localparam int H  = half_w(W);
    localparam int PW = pp_w(H);
    localparam int ZW = 2 * W;

    localparam logic [63:0] MASK_FULL = trunc_mask(H, TRUNC);
    localparam logic [H:0]  LL_MASK   = MASK_FULL[H:0];

    // Parameter sanity: odd or tiny widths break the half split, and the
    // truncation cannot exceed the low half.
    generate
        if ((W % 2) != 0 || W < 4) begin : g_bad_w
            $error("mult_split_seq: W must be even and >= 4");
        end
        if (TRUNC < 0 || TRUNC > (W / 2)) begin : g_bad_trunc
            $error("mult_split_seq: TRUNC must be in 0..W/2");
        end
    endgenerate

    state_t           state;
    state_t           state_next;
    step_t            step;
    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic             approx_q;
    logic [ZW-1:0]    acc;
    logic [ZW-1:0]    z_q;

    logic signed [H:0]    a_lo;
    logic signed [H:0]    a_hi;
    logic signed [H:0]    b_lo;
    logic signed [H:0]    b_hi;
    logic signed [H:0]    pp_a;
    logic signed [H:0]    pp_b;
    logic signed [PW-1:0] pp_z;
    logic [ZW-1:0]        term_ext;
    logic [ZW-1:0]        term_sh;
    logic [ZW-1:0]        acc_sum;

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: accept in IDLE, four CALC steps, hold DONE until taken.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (i_valid)         state_next = CALC;
            CALC:    if (step == 2'd3)    state_next = DONE;
            DONE:    if (i_ready)         state_next = IDLE;
            default:                      state_next = IDLE;
        endcase
    end

    assign o_ready = (state == IDLE);
    assign o_busy  = (state != IDLE);
    assign o_valid = (state == DONE);
    assign o_z     = z_q;

    // Operand split: low halves get a zero sign bit, high halves keep the
    // operand MSB, so a = a_hi*2^H + a_lo holds for every signed input.
    always_comb begin
        a_lo = {1'b0, a_q[H-1:0]};
        a_hi = {a_q[W-1], a_q[W-1:H]};
        b_lo = {1'b0, b_q[H-1:0]};
        b_hi = {b_q[W-1], b_q[W-1:H]};
    end

    // Select the partial-product operands for the current step.
    always_comb begin
        pp_a = a_lo;
        pp_b = b_lo;
        case (step)
            2'd0: begin
                pp_a = approx_q ? (a_lo & LL_MASK) : a_lo;
                pp_b = approx_q ? (b_lo & LL_MASK) : b_lo;
            end
            2'd1: begin
                pp_a = a_lo;
                pp_b = b_hi;
            end
            2'd2: begin
                pp_a = a_hi;
                pp_b = b_lo;
            end
            default: begin
                pp_a = a_hi;
                pp_b = b_hi;
            end
        endcase
    end

    mult_pp_unit #(
        .H (H)
    ) u_pp (
        .i_a (pp_a),
        .i_b (pp_b),
        .o_z (pp_z)
    );

    // Sign-extend the partial product, weight it by its half positions and
    // add. The true product always fits 2W bits, so wrap never occurs.
    always_comb begin
        term_ext = {{(ZW-PW){pp_z[PW-1]}}, pp_z};
        case (step)
            2'd0:    term_sh = term_ext;
            2'd1,
            2'd2:    term_sh = term_ext << H;
            default: term_sh = term_ext << (2 * H);
        endcase
        acc_sum = acc + term_sh;
    end

    // Capture on accept, accumulate in CALC, publish the result on DONE entry.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            step     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            approx_q <= 1'b0;
            acc      <= '0;
            z_q      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        a_q      <= i_a;
                        b_q      <= i_b;
                        approx_q <= i_approx;
                        acc      <= '0;
                        step     <= '0;
                    end
                end
                CALC: begin
                    acc  <= acc_sum;
                    step <= step + 2'd1;
                    if (step == 2'd3) begin
                        z_q <= acc_sum;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_split_seq.sv
// Self-checking bench for mult_split_seq: directed corners, approximate mode,
// backpressure, mid-operation reset and randomized traffic against a model.
module tb_mult_split_seq;

    localparam int W  = 16;
    localparam int TR = 4;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  i_valid = 1'b0;
    logic                  i_approx = 1'b0;
    logic                  i_ready = 1'b1;
    logic signed [W-1:0]   i_a = '0;
    logic signed [W-1:0]   i_b = '0;

    logic                  o_ready, o_valid, o_busy;
    logic signed [2*W-1:0] o_z;
    logic                  o_ready0, o_valid0, o_busy0;
    logic signed [2*W-1:0] o_z0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Main DUT with truncation enabled.
    mult_split_seq #(.W(W), .TRUNC(TR)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_a(i_a), .i_b(i_b), .i_approx(i_approx), .o_valid(o_valid),
        .i_ready(i_ready), .o_z(o_z), .o_busy(o_busy)
    );

    // Twin with TRUNC=0: must be exact whatever i_approx says.
    mult_split_seq #(.W(W), .TRUNC(0)) u_dut0 (
        .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready0),
        .i_a(i_a), .i_b(i_b), .i_approx(i_approx), .o_valid(o_valid0),
        .i_ready(i_ready), .o_z(o_z0), .o_busy(o_busy0)
    );

    // Reference: exact product, minus the bits lost by truncating the
    // unsigned low halves when approximate mode is requested.
    function automatic longint model(input longint a, input longint b,
                                     input bit ap, input int tr);
        longint al, bl, m, ll, llt;
        al  = a & ((64'sd1 <<< (W/2)) - 1);
        bl  = b & ((64'sd1 <<< (W/2)) - 1);
        m   = ~((64'sd1 <<< tr) - 1);
        ll  = al * bl;
        llt = (al & m) * (bl & m);
        return a * b - (ap ? (ll - llt) : 64'sd0);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction: wait for ready, accept, scramble inputs during
    // CALC, measure latency, optionally stall, then release back to IDLE.
    task automatic run_op(input logic signed [W-1:0] a, input logic signed [W-1:0] b,
                          input logic ap, input int stall,
                          output logic signed [2*W-1:0] z, output logic signed [2*W-1:0] zx,
                          output int lat, output bit stable);
        int n;
        n = 0;
        stable = 1'b1;
        while (o_ready !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        i_valid  = 1'b1;
        i_a      = a;
        i_b      = b;
        i_approx = ap;
        i_ready  = (stall == 0);
        tick();
        i_valid  = 1'b0;
        i_a      = W'($urandom);
        i_b      = W'($urandom);
        i_approx = 1'($urandom);
        lat = 1;
        while (o_valid !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        z  = o_z;
        zx = o_z0;
        if (o_valid !== 1'b1) begin
            lat = -1;
            i_ready = 1'b1;
            return;
        end
        if (o_valid0 !== 1'b1) stable = 1'b0;
        for (int k = 0; k < stall; k++) begin
            tick();
            if (o_valid !== 1'b1 || o_z !== z || o_ready !== 1'b0) stable = 1'b0;
        end
        i_ready = 1'b1;
        tick();
        if (o_valid !== 1'b0) stable = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", o_valid); end
        n_cmp++; if (o_z !== '0) begin n_err++; $display("FAIL reset_z: got %0d expected 0", o_z); end
        n_cmp++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", o_busy); end
        n_cmp++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b expected 1", o_ready); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_exact_corners();
        logic signed [W-1:0]   ta [3];
        logic signed [W-1:0]   tb [3];
        logic signed [2*W-1:0] te [3];
        logic signed [2*W-1:0] z, zx;
        int lat;
        bit st;
        ta[0] = -16'sd32768; tb[0] = -16'sd32768; te[0] = 32'sd1073741824;
        ta[1] = 16'sd300;    tb[1] = -16'sd7;     te[1] = -32'sd2100;
        ta[2] = 16'sd32767;  tb[2] = -16'sd32768; te[2] = -32'sd1073709056;
        for (int i = 0; i < 3; i++) begin
            run_op(ta[i], tb[i], 1'b0, 0, z, zx, lat, st);
            n_cmp++; if (z !== te[i]) begin n_err++; $display("FAIL corner%0d_z: got %0d expected %0d", i, z, te[i]); end
            n_cmp++; if (lat != 5) begin n_err++; $display("FAIL corner%0d_latency: got %0d expected 5", i, lat); end
        end
    endtask

    task automatic test_approx();
        logic signed [2*W-1:0] z, zx;
        int lat;
        bit st;
        run_op(16'sd255, 16'sd255, 1'b1, 0, z, zx, lat, st);
        n_cmp++; if (z !== 32'sd57600) begin n_err++; $display("FAIL approx_z: got %0d expected 57600", z); end
        n_cmp++; if (zx !== 32'sd65025) begin n_err++; $display("FAIL approx_trunc0_z: got %0d expected 65025", zx); end
        run_op(16'sd255, 16'sd255, 1'b0, 0, z, zx, lat, st);
        n_cmp++; if (z !== 32'sd65025) begin n_err++; $display("FAIL exact255_z: got %0d expected 65025", z); end
    endtask

    task automatic test_backpressure();
        logic signed [2*W-1:0] held, z, zx;
        int lat, n;
        bit ok, st;
        i_valid = 1'b1; i_a = 16'sd1234; i_b = -16'sd567; i_approx = 1'b0; i_ready = 1'b0;
        tick();
        i_valid = 1'b0;
        n = 0;
        while (o_valid !== 1'b1 && n < 40) begin tick(); n++; end
        held = o_z;
        n_cmp++; if (held !== -32'sd699678) begin n_err++; $display("FAIL bp_result: got %0d expected -699678", held); end
        ok = 1'b1;
        for (int k = 0; k < 10; k++) begin
            i_valid = 1'b1; i_a = 16'sd99; i_b = 16'sd99;
            tick();
            if (o_z !== held || o_ready !== 1'b0 || o_valid !== 1'b1) ok = 1'b0;
        end
        n_cmp++; if (!ok) begin n_err++; $display("FAIL bp_hold: got unstable expected z=%0d ready=0 valid=1", held); end
        i_valid = 1'b0;
        i_ready = 1'b1;
        tick();
        n_cmp++; if (o_busy !== 1'b0 || o_valid !== 1'b0) begin n_err++; $display("FAIL bp_release: got busy=%b valid=%b expected 0 0", o_busy, o_valid); end
        run_op(-16'sd321, 16'sd77, 1'b0, 0, z, zx, lat, st);
        n_cmp++; if (z !== -32'sd24717) begin n_err++; $display("FAIL bp_next_z: got %0d expected -24717", z); end
    endtask

    task automatic test_reset_mid();
        logic signed [2*W-1:0] z, zx;
        int lat;
        bit st;
        i_valid = 1'b1; i_a = 16'sd1000; i_b = 16'sd1000; i_approx = 1'b0; i_ready = 1'b1;
        tick();
        i_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid: got %b expected 0", o_valid); end
        n_cmp++; if (o_z !== '0) begin n_err++; $display("FAIL midrst_z: got %0d expected 0", o_z); end
        n_cmp++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL midrst_ready: got %b expected 1", o_ready); end
        rst = 1'b0;
        tick();
        n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL midrst_nopulse: got %b expected 0", o_valid); end
        run_op(-16'sd1, -16'sd1, 1'b0, 0, z, zx, lat, st);
        n_cmp++; if (z !== 32'sd1) begin n_err++; $display("FAIL midrst_after_z: got %0d expected 1", z); end
    endtask

    task automatic test_back_to_back();
        logic signed [2*W-1:0] z, zx;
        int lat;
        bit st;
        run_op(16'sd12345, -16'sd2, 1'b0, 0, z, zx, lat, st);
        n_cmp++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready: got %b expected 1", o_ready); end
        run_op(-16'sd129, 16'sd257, 1'b1, 0, z, zx, lat, st);
        n_cmp++; if (lat != 5) begin n_err++; $display("FAIL b2b_latency: got %0d expected 5", lat); end
        n_cmp++; if (z !== 32'(model(-129, 257, 1'b1, TR))) begin n_err++; $display("FAIL b2b_z: got %0d expected %0d", z, 32'(model(-129, 257, 1'b1, TR))); end
    endtask

    task automatic test_random();
        logic signed [W-1:0]   a, b;
        logic signed [2*W-1:0] z, zx, ez, ex;
        logic ap;
        int stall, lat;
        bit st;
        for (int i = 0; i < 3000; i++) begin
            a  = W'($urandom);
            b  = W'($urandom);
            ap = 1'($urandom);
            stall = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
            run_op(a, b, ap, stall, z, zx, lat, st);
            ez = 32'(model(a, b, ap, TR));
            ex = 32'(model(a, b, 1'b0, 0));
            n_cmp++; if (z !== ez) begin n_err++; $display("FAIL rand%0d_z: a=%0d b=%0d ap=%b got %0d expected %0d", i, a, b, ap, z, ez); end
            n_cmp++; if (zx !== ex) begin n_err++; $display("FAIL rand%0d_trunc0_z: a=%0d b=%0d got %0d expected %0d", i, a, b, zx, ex); end
            n_cmp++; if (lat != 5) begin n_err++; $display("FAIL rand%0d_latency: got %0d expected 5", i, lat); end
            n_cmp++; if (!st) begin n_err++; $display("FAIL rand%0d_stall_hold: got unstable expected stable (stall %0d)", i, stall); end
        end
    endtask

    initial begin
        test_reset();
        test_exact_corners();
        test_approx();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
